// File: rtl/ren_issue_if.sv
// Request/issue bus of the read-enable issue stage; slave side is the stage, master the upstream feeder.
// Optional statistics signals exist only when REN_ISSUE_STATS_EN is defined.
interface ren_issue_if #(
  parameter int AW      = 8,
  parameter int MAX_OUT = 2,
  parameter int OW      = $clog2(MAX_OUT + 1)
);
  logic          io_req_valid;
  logic          io_req_ready;
  logic [AW-1:0] io_req_addr;
  logic          io_flush;
  logic          io_done;
  logic          io_out_ren;
  logic [AW-1:0] io_out_addr;
  logic [OW-1:0] io_outstanding;
  logic          io_busy;
  logic          io_err;
`ifdef REN_ISSUE_STATS_EN
  logic [15:0]   io_stat_issued;
  logic [15:0]   io_stat_stalls;
`endif

  modport master (
    output io_req_valid, io_req_addr, io_flush, io_done,
    input  io_req_ready, io_out_ren, io_out_addr, io_outstanding, io_busy, io_err
`ifdef REN_ISSUE_STATS_EN
    , input io_stat_issued, io_stat_stalls
`endif
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_flush, io_done,
    output io_req_ready, io_out_ren, io_out_addr, io_outstanding, io_busy, io_err
`ifdef REN_ISSUE_STATS_EN
    , output io_stat_issued, io_stat_stalls
`endif
  );
endinterface

// File: rtl/ren_issue_stage.sv
// Read-request buffer + credit-limited issuer feeding the read-enable chain.
// Define REN_ISSUE_STATS_EN to add the issued/stall statistics counters.
module ren_issue_stage #(
  parameter int DEPTH   = 4,
  parameter int AW      = 8,
  parameter int MAX_OUT = 2
) (
  input  logic       clk,
  input  logic       reset,
  ren_issue_if.slave bus
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] mem [DEPTH];
  logic [OW-1:0] outstanding, outstanding_nxt;
  logic          empty, full, push, issue, done_ok;
  logic          out_ren;
  logic [AW-1:0] out_addr;
  logic          err;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  // A request handshaking in the flush cycle is dropped along with the queue.
  assign bus.io_req_ready = !full && (state != ST_FLUSH);
  assign push  = bus.io_req_valid && bus.io_req_ready && !bus.io_flush;
  assign issue = (state == ST_ACTIVE) && !empty && (outstanding < MAX_OUT_W) && !bus.io_flush;

  // A completion with nothing in flight is an error and returns no credit.
  assign done_ok = bus.io_done && (outstanding != '0);

  always_comb begin
    outstanding_nxt = outstanding;
    if (issue && !done_ok)      outstanding_nxt = outstanding + OW'(1);
    else if (!issue && done_ok) outstanding_nxt = outstanding - OW'(1);
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    if (bus.io_flush) begin
      state_nxt = ST_FLUSH;
    end else begin
      unique case (state)
        // Leaving IDLE on the enqueue edge lets the head issue the very next cycle.
        ST_IDLE:   if (push || !empty) state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (empty && outstanding == '0) state_nxt = ST_IDLE;
        ST_FLUSH:  if (outstanding == '0) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array carries no reset; empty/full come from the pointers alone,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= bus.io_req_addr;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_ren     <= 1'b0;
      out_addr    <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.io_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        if (issue) rd_ptr <= rd_ptr + PW'(1);
      end
      out_ren <= issue;
      if (issue) out_addr <= mem[rd_ptr[IW-1:0]];
      outstanding <= outstanding_nxt;
      if (bus.io_done && outstanding == '0) err <= 1'b1;
    end
  end

  assign bus.io_out_ren     = out_ren;
  assign bus.io_out_addr    = out_addr;
  assign bus.io_outstanding = outstanding;
  assign bus.io_busy        = (state != ST_IDLE) || !empty;
  assign bus.io_err         = err;

`ifdef REN_ISSUE_STATS_EN
  logic [15:0] stat_issued, stat_stalls;
  logic        stall;

  assign stall = (state == ST_ACTIVE) && !empty && (outstanding == MAX_OUT_W);

  // Issued count wraps; stall count saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      if (issue) stat_issued <= stat_issued + 16'd1;
      if (stall && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
    end
  end

  assign bus.io_stat_issued = stat_issued;
  assign bus.io_stat_stalls = stat_stalls;
`endif
endmodule

// File: tb/tb_ren_issue_stage.sv
// Scoreboard bench for ren_issue_stage: accepted addresses are queued and matched against read pulses.
module tb_ren_issue_stage;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n_pulses = 0;
  int   base;
  logic [7:0] sb[$];

  ren_issue_if #(.AW(8), .MAX_OUT(2)) bus ();
  ren_issue_stage #(.DEPTH(4), .AW(8), .MAX_OUT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request for one cycle; queue it as expected output if the handshake completes.
  task automatic offer(input logic [7:0] a);
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = a;
    if (bus.io_req_ready && !bus.io_flush) sb.push_back(a);
    tick();
    bus.io_req_valid = 1'b0;
  endtask

  task automatic done_pulse();
    bus.io_done = 1'b1;
    tick();
    bus.io_done = 1'b0;
  endtask

  // Every pulse must match the oldest accepted, not-yet-issued address.
  always @(negedge clk) begin
    if (!reset && bus.io_out_ren) begin
      n_pulses++;
      if (sb.size() == 0) check("unexpected_pulse", {24'd0, bus.io_out_addr}, 32'hFFFF_FFFF);
      else                check("pulse_addr", {24'd0, bus.io_out_addr}, {24'd0, sb.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.io_req_valid = 1'b0;
    bus.io_req_addr  = '0;
    bus.io_flush     = 1'b0;
    bus.io_done      = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_ren", bus.io_out_ren, 0);
    check("rst_addr", bus.io_out_addr, 0);
    check("rst_outstanding", bus.io_outstanding, 0);
    check("rst_err", bus.io_err, 0);
    check("rst_ready", bus.io_req_ready, 1);
    check("rst_busy", bus.io_busy, 0);

    // 1: single request, pulse exactly two cycles after acceptance
    offer(8'h11);
    check("t1_c2_ren", bus.io_out_ren, 0);
    tick();
    check("t1_c3_ren", bus.io_out_ren, 1);
    check("t1_c3_addr", bus.io_out_addr, 8'h11);
    check("t1_c3_out", bus.io_outstanding, 1);
    tick();
    check("t1_c4_ren", bus.io_out_ren, 0);
    check("t1_c4_addr_hold", bus.io_out_addr, 8'h11);
    done_pulse();
    check("t1_out0", bus.io_outstanding, 0);
    tick();
    check("t1_idle_busy", bus.io_busy, 0);

    // 2: six back-to-back requests, credits cap issue at two, FIFO fills
    base = n_pulses;
    offer(8'h01);
    offer(8'h02);
    offer(8'h03);
    offer(8'h04);
    check("t2_ready_2q", bus.io_req_ready, 1);
    offer(8'h05);
    offer(8'h06);
    check("t2_ready_full", bus.io_req_ready, 0);
    check("t2_pulses", n_pulses - base, 2);
    check("t2_out", bus.io_outstanding, 2);
    check("t2_busy", bus.io_busy, 1);
    done_pulse();
    check("t2_done_no_same_cycle_issue", bus.io_out_ren, 0);
    check("t2_out_after_done", bus.io_outstanding, 1);
    tick();
    check("t2_issue03_ren", bus.io_out_ren, 1);
    check("t2_issue03_addr", bus.io_out_addr, 8'h03);
    check("t2_ready_after_pop", bus.io_req_ready, 1);
    check("t2_out_after_issue", bus.io_outstanding, 2);

    // 3: issue and done in the same cycle with one in flight
    bus.io_done = 1'b1;
    tick();
    check("t3_out_pre", bus.io_outstanding, 1);
    tick();
    bus.io_done = 1'b0;
    check("t3_ren", bus.io_out_ren, 1);
    check("t3_addr", bus.io_out_addr, 8'h04);
    check("t3_out_unchanged", bus.io_outstanding, 1);
    tick();
    check("t3_issue05", bus.io_out_addr, 8'h05);
    tick();
    check("t3_stall_ren", bus.io_out_ren, 0);

    // 4: flush with three queued and two in flight; handshake in flush cycle is dropped
    offer(8'h07);
    offer(8'h08);
    check("t4_out", bus.io_outstanding, 2);
    base = n_pulses;
    bus.io_flush     = 1'b1;
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = 8'h99;
    sb.delete();
    tick();
    bus.io_flush     = 1'b0;
    bus.io_req_valid = 1'b0;
    check("t4_ready_flush", bus.io_req_ready, 0);
    check("t4_busy_flush", bus.io_busy, 1);
    tick();
    done_pulse();
    check("t4_out1", bus.io_outstanding, 1);
    done_pulse();
    check("t4_out0", bus.io_outstanding, 0);
    tick();
    check("t4_idle_busy", bus.io_busy, 0);
    check("t4_idle_ready", bus.io_req_ready, 1);
    check("t4_no_pulses", n_pulses - base, 0);
    offer(8'h21);
    tick();
    check("t4_new_ren", bus.io_out_ren, 1);
    check("t4_new_addr", bus.io_out_addr, 8'h21);
    done_pulse();
    tick();
    check("t4_sb_empty", sb.size(), 0);
    check("t4_err_clean", bus.io_err, 0);

    // 5: spurious done sets sticky error
    done_pulse();
    check("t5_err", bus.io_err, 1);
    check("t5_out", bus.io_outstanding, 0);
    tick();
    tick();
    tick();
    check("t5_err_sticky", bus.io_err, 1);
`ifdef REN_ISSUE_STATS_EN
    check("t6_issued", bus.io_stat_issued, 7);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_err_reset", bus.io_err, 0);

`ifdef REN_ISSUE_STATS_EN
    // 6: three requests, two issue, then exactly five stalled cycles
    check("t6_rst_issued", bus.io_stat_issued, 0);
    check("t6_rst_stalls", bus.io_stat_stalls, 0);
    offer(8'h31);
    offer(8'h32);
    offer(8'h33);
    for (int i = 0; i < 5; i++) tick();
    check("t6_stalls", bus.io_stat_stalls, 5);
    check("t6_issued2", bus.io_stat_issued, 2);
    sb.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
